// File: rtl/ps2_rx.sv
// PS/2 device-to-host receiver: synchronizes the raw lines, deframes 11-bit
// frames (start, 8 data LSB-first, odd parity, stop) and queues good bytes in a show-ahead FIFO.
module ps2_rx #(
  parameter int DEPTH   = 8,
  parameter int TIMEOUT = 50000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  input  logic       rd_en,
  output logic [7:0] code,
  output logic       valid,
  output logic       frame_err,
  output logic       overflow
);
  localparam int AW = $clog2(DEPTH);
  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

  logic [1:0]    clk_sync, dat_sync;
  logic          clk_prev;
  logic          fall, bit_in;

  state_t        state;
  logic [2:0]    bit_cnt;
  logic [7:0]    shreg;
  logic          par_bit;
  logic [TW-1:0] to_cnt;
  logic          push;

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic          full, do_pop, do_push;

  // Lines idle high, so the synchronizers and edge history reset to 1 to
  // avoid a phantom falling edge right after reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      clk_sync <= 2'b11;
      dat_sync <= 2'b11;
      clk_prev <= 1'b1;
    end else begin
      clk_sync <= {clk_sync[0], ps2_clk};
      dat_sync <= {dat_sync[0], ps2_data};
      clk_prev <= clk_sync[1];
    end
  end

  assign fall   = clk_prev & ~clk_sync[1];
  assign bit_in = dat_sync[1];

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      bit_cnt   <= '0;
      shreg     <= '0;
      par_bit   <= 1'b0;
      to_cnt    <= '0;
      push      <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      push      <= 1'b0;
      frame_err <= 1'b0;

      if (state == IDLE || fall) begin
        to_cnt <= '0;
      end else if (to_cnt == TW'(TIMEOUT - 1)) begin
        state     <= IDLE;
        shreg     <= '0;
        to_cnt    <= '0;
        frame_err <= 1'b1;
      end else begin
        to_cnt <= to_cnt + TW'(1);
      end

      if (fall) begin
        case (state)
          IDLE: if (!bit_in) begin
            state   <= DATA;
            bit_cnt <= '0;
          end
          DATA: begin
            shreg   <= {bit_in, shreg[7:1]};
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) state <= PARITY;
          end
          PARITY: begin
            par_bit <= bit_in;
            state   <= STOP;
          end
          STOP: begin
            state <= IDLE;
            if ((^{shreg, par_bit}) && bit_in) push      <= 1'b1;
            else                               frame_err <= 1'b1;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign valid   = (count != '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign do_pop  = rd_en && valid;
  assign do_push = push && (!full || do_pop);
  assign code    = valid ? mem[rd_ptr] : 8'h00;

  always_ff @(posedge clk) begin
    if (!rst && do_push) mem[wr_ptr] <= shreg;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
      if (push && !do_push) overflow <= 1'b1;
    end
  end
endmodule

// File: tb/tb_ps2_rx.sv
// Bench for ps2_rx: directed frame scenarios plus a random frame/consumer run
// checked against a byte-queue reference model.
module tb_ps2_rx;
  localparam int DEPTH = 8;
  localparam int TO    = 3000;

  logic       clk = 1'b0, rst = 1'b1, ps2_clk = 1'b1, ps2_data = 1'b1, rd_en = 1'b0;
  logic [7:0] code;
  logic       valid, frame_err, overflow;

  int errors = 0, checks = 0, ferr_cnt = 0;
  logic [7:0] q[$];

  ps2_rx #(.DEPTH(DEPTH), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .ps2_clk(ps2_clk), .ps2_data(ps2_data), .rd_en(rd_en),
    .code(code), .valid(valid), .frame_err(frame_err), .overflow(overflow)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (frame_err === 1'b1) ferr_cnt++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    ps2_clk = 1'b1;
    ps2_data = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    q.delete();
  endtask

  task automatic ps2_bit(input logic b, input int half);
    ps2_data = b;
    repeat (half) @(negedge clk);
    ps2_clk = 1'b0;
    repeat (half) @(negedge clk);
    ps2_clk = 1'b1;
  endtask

  // Reference: a frame is good iff parity makes the 9-bit count odd and stop=1.
  task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop,
                            input int half, input bit pop_at_push, output int lat);
    logic par;
    par = ~(^b) ^ bad_par;
    ps2_bit(1'b0, half);
    for (int i = 0; i < 8; i++) ps2_bit(b[i], half);
    ps2_bit(par, half);
    ps2_data = !bad_stop;
    repeat (half) @(negedge clk);
    ps2_clk = 1'b0;
    if (!bad_par && !bad_stop) q.push_back(b);
    lat = 0;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      if (valid && lat == 0) lat = k;
      if (pop_at_push && k == 3) rd_en = 1'b1;
      if (pop_at_push && k == 4) rd_en = 1'b0;
    end
    repeat (half - 4) @(negedge clk);
    ps2_clk = 1'b1;
    ps2_data = 1'b1;
    repeat (half) @(negedge clk);
  endtask

  task automatic send_partial(input int nbits, input int half);
    ps2_bit(1'b0, half);
    for (int i = 0; i < nbits; i++) ps2_bit(1'($urandom_range(0, 1)), half);
  endtask

  task automatic pop_chk(input string tag, input logic [7:0] exp);
    check({tag, "_valid"}, valid, 1);
    check(tag, code, exp);
    rd_en = 1'b1;
    @(negedge clk);
    rd_en = 1'b0;
  endtask

  initial begin
    int lat, base, exp_err;
    bit done;

    // reset state
    do_reset();
    check("rst_valid", valid, 0);
    check("rst_ferr", frame_err, 0);
    check("rst_ovf", overflow, 0);
    check("rst_code", code, 0);

    // good 0x1C at slow PS/2 clock
    base = ferr_cnt;
    send_frame(8'h1C, 0, 0, 1000, 0, lat);
    check("1c_latency_ok", (lat >= 1 && lat <= 4), 1);
    check("1c_code", code, 8'h1C);
    check("1c_ferr", ferr_cnt - base, 0);
    pop_chk("1c_pop", 8'h1C);
    check("1c_empty", valid, 0);

    // bad parity
    base = ferr_cnt;
    send_frame(8'h1C, 1, 0, 20, 0, lat);
    check("par_ferr", ferr_cnt - base, 1);
    check("par_valid", valid, 0);

    // bad stop
    base = ferr_cnt;
    send_frame(8'h3A, 0, 1, 20, 0, lat);
    check("stop_ferr", ferr_cnt - base, 1);
    check("stop_valid", valid, 0);

    // overflow: 9 frames, no reads
    do_reset();
    for (int i = 1; i <= 9; i++) send_frame(8'(i), 0, 0, 20, 0, lat);
    check("ovf_flag", overflow, 1);
    check("ovf_head", code, 8'h01);
    for (int i = 1; i <= 8; i++) pop_chk("ovf_pop", 8'(i));
    check("ovf_empty", valid, 0);
    check("ovf_sticky", overflow, 1);

    // timeout on a partial frame, then a good frame
    do_reset();
    base = ferr_cnt;
    send_partial(3, 20);
    repeat (TO + 20) @(negedge clk);
    check("to_ferr_mid", ferr_cnt - base, 1);
    send_frame(8'hF0, 0, 0, 20, 0, lat);
    check("to_ferr", ferr_cnt - base, 1);
    pop_chk("to_pop", 8'hF0);
    check("to_empty", valid, 0);

    // full FIFO with a pop in the push cycle
    do_reset();
    for (int i = 0; i < 8; i++) send_frame(8'h10 + 8'(i), 0, 0, 20, 0, lat);
    check("fullpp_ovf_pre", overflow, 0);
    send_frame(8'h5A, 0, 0, 20, 1, lat);
    check("fullpp_ovf", overflow, 0);
    for (int i = 1; i < 8; i++) pop_chk("fullpp_pop", 8'h10 + 8'(i));
    pop_chk("fullpp_last", 8'h5A);
    check("fullpp_empty", valid, 0);

    // reset mid-frame
    do_reset();
    send_partial(5, 20);
    base = ferr_cnt;
    do_reset();
    send_frame(8'h29, 0, 0, 20, 0, lat);
    check("midrst_ferr", ferr_cnt - base, 0);
    check("midrst_valid", valid, 1);
    check("midrst_code", code, 8'h29);

    // random frames against a random consumer
    do_reset();
    base = ferr_cnt;
    exp_err = 0;
    done = 0;
    fork
      begin
        for (int n = 0; n < 30; n++) begin
          int kind, half, l;
          kind = int'($urandom_range(0, 3));
          half = int'($urandom_range(8, 25));
          send_frame(8'($urandom), kind == 1, kind == 2, half, 0, l);
          if (kind == 1 || kind == 2) exp_err++;
        end
        repeat (20) @(negedge clk);
        done = 1;
      end
      begin
        while (!done) begin
          @(negedge clk);
          rd_en = 1'b0;
          if (valid && $urandom_range(0, 2) == 0) begin
            if (q.size() == 0) check("rnd_spurious", 1, 0);
            else check("rnd_code", code, q.pop_front());
            rd_en = 1'b1;
          end
        end
        rd_en = 1'b0;
      end
    join
    for (int i = 0; i < 16 && valid; i++) begin
      if (q.size() == 0) check("rnd_spurious", 1, 0);
      else pop_chk("rnd_drain", q.pop_front());
    end
    check("rnd_model_empty", q.size(), 0);
    check("rnd_valid", valid, 0);
    check("rnd_ferr", ferr_cnt - base, exp_err);
    check("rnd_ovf", overflow, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
